// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: default widths,
// the misaligned-fetch exception code and the fetch FSM state encoding.
package if_fetch_ctrl_pkg;

   localparam int ADDR_W_DEF   = 32;
   localparam int DATA_W_DEF   = 32;
   localparam int EXC_W_DEF    = 5;
   localparam int EXC_ADEL_DEF = 4;

   // REQ : free to issue the next fetch address
   // WAIT: one request accepted, waiting for its data
   // HOLD: output buffer full, waiting for ID to take it (or a redirect)
   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl_out_buf.sv
// One-entry {inst, pc, exc} output register toward ID. Clear wins over load;
// with neither asserted the entry simply holds.
module if_out_buf #(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int EXC_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             clear,
   input  logic [DW-1:0]    load_inst,
   input  logic [AW-1:0]    load_pc,
   input  logic [EXC_W-1:0] load_exc,
   output logic             valid,
   output logic [DW-1:0]    inst,
   output logic [AW-1:0]    pc,
   output logic [EXC_W-1:0] exc
);

   logic             valid_reg;
   logic [DW-1:0]    inst_reg;
   logic [AW-1:0]    pc_reg;
   logic [EXC_W-1:0] exc_reg;

   // Entry register: reset to all-zero, clear only drops the valid flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg <= 1'b0;
         inst_reg  <= '0;
         pc_reg    <= '0;
         exc_reg   <= '0;
      end else if (clear) begin
         valid_reg <= 1'b0;
      end else if (load) begin
         valid_reg <= 1'b1;
         inst_reg  <= load_inst;
         pc_reg    <= load_pc;
         exc_reg   <= load_exc;
      end
   end

   assign valid = valid_reg;
   assign inst  = inst_reg;
   assign pc    = pc_reg;
   assign exc   = exc_reg;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer between the PC/translation stage and the
// instruction SRAM-like port. Keeps at most one request in flight, buffers
// one instruction toward ID, and drops responses made stale by a redirect.
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter int AW       = ADDR_W_DEF,
   parameter int DW       = DATA_W_DEF,
   parameter int EXC_W    = EXC_W_DEF,
   parameter int EXC_ADEL = EXC_ADEL_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    pc,
   input  logic [AW-1:0]    pc_paddr,
   input  logic             pc_valid,
   input  logic             flush,
   input  logic             id_allowin,
   output logic             inst_req,
   output logic [AW-1:0]    inst_addr,
   input  logic             inst_addr_ok,
   input  logic             inst_data_ok,
   input  logic [DW-1:0]    inst_rdata,
   output logic             pc_en,
   output logic             id_valid,
   output logic [DW-1:0]    id_inst,
   output logic [AW-1:0]    id_pc,
   output logic [EXC_W-1:0] id_exc
);

   localparam logic [EXC_W-1:0] ADEL_CODE = EXC_W'(EXC_ADEL);

   fetch_state_t     state_reg, state_next;
   logic             discard_reg, discard_next;
   logic [AW-1:0]    req_pc_reg, req_pc_next;

   logic             buf_load;
   logic             buf_clear;
   logic [DW-1:0]    buf_load_inst;
   logic [AW-1:0]    buf_load_pc;
   logic [EXC_W-1:0] buf_load_exc;
   logic             buf_free;

   // The buffer counts as free when empty or when ID drains it this cycle.
   assign buf_free  = ~(id_valid & ~id_allowin);
   assign inst_addr = pc_paddr;

   // State, stale-response flag and the PC of the request in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_REQ;
         discard_reg <= 1'b0;
         req_pc_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         discard_reg <= discard_next;
         req_pc_reg  <= req_pc_next;
      end
   end

   // Next-state and output decode; a redirect overrides every other event.
   always_comb begin
      state_next    = state_reg;
      discard_next  = discard_reg;
      req_pc_next   = req_pc_reg;
      inst_req      = 1'b0;
      pc_en         = 1'b0;
      buf_load      = 1'b0;
      buf_clear     = flush;
      buf_load_inst = '0;
      buf_load_pc   = '0;
      buf_load_exc  = '0;

      unique case (state_reg)
         ST_REQ: begin
            inst_req = pc_valid & ~flush & buf_free;
            if (flush) begin
               state_next = ST_REQ;
            end else if (inst_req & inst_addr_ok) begin
               pc_en       = 1'b1;
               req_pc_next = pc;
               state_next  = ST_WAIT;
            end else if (~pc_valid & buf_free) begin
               // Misaligned PC: emit an exception bubble, never touch memory.
               buf_load     = 1'b1;
               buf_load_pc  = pc;
               buf_load_exc = ADEL_CODE;
               state_next   = ST_HOLD;
            end
         end

         ST_WAIT: begin
            if (inst_data_ok) begin
               discard_next = 1'b0;
               if (~flush & ~discard_reg) begin
                  buf_load      = 1'b1;
                  buf_load_inst = inst_rdata;
                  buf_load_pc   = req_pc_reg;
                  state_next    = ST_HOLD;
               end else begin
                  state_next = ST_REQ;
               end
            end else if (flush) begin
               // The response is still owed by memory; swallow it when it lands.
               discard_next = 1'b1;
            end
         end

         ST_HOLD: begin
            if (flush) begin
               state_next = ST_REQ;
            end else if (id_allowin & (id_exc == '0)) begin
               // Exception bubbles wait for the redirect they will cause.
               buf_clear  = 1'b1;
               state_next = ST_REQ;
            end
         end

         default: begin
            state_next   = ST_REQ;
            discard_next = 1'b0;
         end
      endcase
   end

   if_out_buf #(
      .AW    (AW),
      .DW    (DW),
      .EXC_W (EXC_W)
   ) u_out_buf (
      .clk       (clk),
      .reset     (reset),
      .load      (buf_load),
      .clear     (buf_clear),
      .load_inst (buf_load_inst),
      .load_pc   (buf_load_pc),
      .load_exc  (buf_load_exc),
      .valid     (id_valid),
      .inst      (id_inst),
      .pc        (id_pc),
      .exc       (id_exc)
   );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed cycle-by-cycle stimulus with literal
// checkpoints, plus a transaction-level model checked on every cycle.
module tb_if_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] pc_paddr;
   logic        pc_valid;
   logic        flush;
   logic        id_allowin;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        pc_en;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [4:0]  id_exc;

   always #5 clk = ~clk;

   if_fetch_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .pc           (pc),
      .pc_paddr     (pc_paddr),
      .pc_valid     (pc_valid),
      .flush        (flush),
      .id_allowin   (id_allowin),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .pc_en        (pc_en),
      .id_valid     (id_valid),
      .id_inst      (id_inst),
      .id_pc        (id_pc),
      .id_exc       (id_exc)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Literal checkpoint posted by the stimulus, consumed by the checker.
   int          lit_seq = 0;
   string       lit_name;
   logic        lit_req, lit_pen, lit_vld, lit_data;
   logic [31:0] lit_addr, lit_inst, lit_pc;
   logic [4:0]  lit_exc;

   // Model: a fetch in flight (busy), whether its answer is stale, and the buffer.
   typedef struct packed {
      logic        busy;
      logic        stale;
      logic        bvalid;
      logic [31:0] binst;
      logic [31:0] bpc;
      logic [4:0]  bexc;
      logic [31:0] rpc;
   } model_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Checker: runs on every falling edge, inputs and outputs are settled there.
   initial begin
      model_t m, nx;
      bit     m_ok, nx_ok;
      int     lit_seen;
      logic   can_issue, e_req, e_pen;
      nx = '0; nx_ok = 0; lit_seen = 0;
      forever begin
         @(negedge clk);
         m    = nx;
         m_ok = nx_ok;
         can_issue = m_ok && !m.busy && !m.bvalid;
         e_req     = can_issue && pc_valid && !flush;
         e_pen     = e_req && inst_addr_ok;
         if (m_ok) begin
            chk("model inst_req", {31'b0, inst_req}, {31'b0, e_req});
            chk("model pc_en", {31'b0, pc_en}, {31'b0, e_pen});
            if (e_req) chk("model inst_addr", inst_addr, pc_paddr);
            chk("model id_valid", {31'b0, id_valid}, {31'b0, m.bvalid});
            if (m.bvalid) begin
               chk("model id_inst", id_inst, m.binst);
               chk("model id_pc", id_pc, m.bpc);
               chk("model id_exc", {27'b0, id_exc}, {27'b0, m.bexc});
            end
            if (flush) chk("pc_en with flush", {31'b0, pc_en}, 32'd0);
         end
         if (lit_seq != lit_seen) begin
            lit_seen = lit_seq;
            $display("check %s @%0t: req=%0b pc_en=%0b id_valid=%0b id_inst=%h id_pc=%h id_exc=%0d",
                     lit_name, $time, inst_req, pc_en, id_valid, id_inst, id_pc, id_exc);
            chk({lit_name, " inst_req"}, {31'b0, inst_req}, {31'b0, lit_req});
            chk({lit_name, " pc_en"}, {31'b0, pc_en}, {31'b0, lit_pen});
            if (lit_req) chk({lit_name, " inst_addr"}, inst_addr, lit_addr);
            chk({lit_name, " id_valid"}, {31'b0, id_valid}, {31'b0, lit_vld});
            if (lit_data) begin
               chk({lit_name, " id_inst"}, id_inst, lit_inst);
               chk({lit_name, " id_pc"}, id_pc, lit_pc);
               chk({lit_name, " id_exc"}, {27'b0, id_exc}, {27'b0, lit_exc});
            end
         end
         // Advance the model by one clock.
         nx = m;
         if (reset) begin
            nx    = '0;
            nx_ok = 1;
         end else if (m_ok) begin
            if (flush) begin
               nx.bvalid = 1'b0;
               if (m.busy && !inst_data_ok) nx.stale = 1'b1;
               else begin
                  nx.busy  = 1'b0;
                  nx.stale = 1'b0;
               end
            end else if (m.busy) begin
               if (inst_data_ok) begin
                  nx.busy  = 1'b0;
                  nx.stale = 1'b0;
                  if (!m.stale) begin
                     nx.bvalid = 1'b1;
                     nx.binst  = inst_rdata;
                     nx.bpc    = m.rpc;
                     nx.bexc   = 5'd0;
                  end
               end
            end else if (m.bvalid) begin
               if (m.bexc == 5'd0 && id_allowin) nx.bvalid = 1'b0;
            end else if (e_pen) begin
               nx.busy = 1'b1;
               nx.rpc  = pc;
            end else if (!pc_valid) begin
               nx.bvalid = 1'b1;
               nx.binst  = 32'd0;
               nx.bpc    = pc;
               nx.bexc   = 5'd4;
            end
         end
      end
   end

   task automatic drv(input logic rst, input logic [31:0] p, input logic [31:0] pa,
                      input logic fl, input logic al, input logic aok, input logic dok,
                      input logic [31:0] rd);
      reset        = rst;
      pc           = p;
      pc_paddr     = pa;
      pc_valid     = (p[1:0] == 2'b00);
      flush        = fl;
      id_allowin   = al;
      inst_addr_ok = aok;
      inst_data_ok = dok;
      inst_rdata   = rd;
   endtask

   task automatic lit(input string nm, input logic rq, input logic pe, input logic [31:0] ad,
                      input logic v, input logic [31:0] ins, input logic [31:0] ipc,
                      input logic [4:0] ex, input logic dchk);
      lit_name = nm;
      lit_req  = rq;
      lit_pen  = pe;
      lit_addr = ad;
      lit_vld  = v;
      lit_inst = ins;
      lit_pc   = ipc;
      lit_exc  = ex;
      lit_data = dchk;
      lit_seq++;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Directed stimulus, one line per cycle.
   initial begin
      drv(1, 32'hBFC00000, 32'h1FC00000, 0, 1, 0, 0, 32'h0);
      tick; tick; tick;

      // 1: first fetch, addr_ok then data_ok, delivered two cycles after addr_ok
      drv(0, 32'hBFC00000, 32'h1FC00000, 0, 1, 0, 0, 32'h0);
      lit("reset state", 1, 0, 32'h1FC00000, 0, 32'h0, 32'h0, 5'd0, 1); tick;
      drv(0, 32'hBFC00000, 32'h1FC00000, 0, 1, 1, 0, 32'h0);
      lit("t1 addr_ok", 1, 1, 32'h1FC00000, 0, 32'h0, 32'h0, 5'd0, 0); tick;
      drv(0, 32'hBFC00004, 32'h1FC00004, 0, 1, 0, 1, 32'h24080001);
      lit("t1 wait", 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0); tick;

      // 2: ID stalls for five cycles, then accepts
      drv(0, 32'hBFC00004, 32'h1FC00004, 0, 0, 0, 0, 32'h0);
      lit("t1 deliver", 0, 0, 32'h0, 1, 32'h24080001, 32'hBFC00000, 5'd0, 1); tick;
      for (int i = 0; i < 4; i++) begin
         lit("t2 stall", 0, 0, 32'h0, 1, 32'h24080001, 32'hBFC00000, 5'd0, 1); tick;
      end
      drv(0, 32'hBFC00004, 32'h1FC00004, 0, 1, 0, 0, 32'h0);
      lit("t2 release", 0, 0, 32'h0, 1, 32'h24080001, 32'hBFC00000, 5'd0, 1); tick;
      drv(0, 32'hBFC00004, 32'h1FC00004, 0, 1, 1, 0, 32'h0);
      lit("t2 reissue", 1, 1, 32'h1FC00004, 0, 32'h0, 32'h0, 5'd0, 0); tick;

      // 3: redirect while waiting; the late response is dropped
      drv(0, 32'hBFC00008, 32'h1FC00008, 1, 1, 0, 0, 32'h0);
      lit("t3 flush in wait", 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0); tick;
      drv(0, 32'hBFC00100, 32'h1FC00100, 0, 1, 0, 0, 32'h0);
      lit("t3 stale wait", 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0); tick;
      tick;
      drv(0, 32'hBFC00100, 32'h1FC00100, 0, 1, 0, 1, 32'hDEADBEEF);
      lit("t3 stale data", 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0); tick;
      drv(0, 32'hBFC00100, 32'h1FC00100, 0, 1, 1, 0, 32'h0);
      lit("t3 new pc", 1, 1, 32'h1FC00100, 0, 32'h0, 32'h0, 5'd0, 0); tick;

      // 4: redirect coincident with data_ok
      drv(0, 32'hBFC00104, 32'h1FC00104, 1, 1, 0, 1, 32'h11111111);
      lit("t4 flush+data", 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0); tick;
      drv(0, 32'hBFC00200, 32'h1FC00200, 0, 1, 1, 0, 32'h0);
      lit("t4 reissue", 1, 1, 32'h1FC00200, 0, 32'h0, 32'h0, 5'd0, 0); tick;
      drv(0, 32'hBFC00204, 32'h1FC00204, 0, 1, 0, 1, 32'h22222222);
      lit("t4 wait", 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0); tick;
      drv(0, 32'hBFC00204, 32'h1FC00204, 0, 1, 0, 0, 32'h0);
      lit("t4 deliver", 0, 0, 32'h0, 1, 32'h22222222, 32'hBFC00200, 5'd0, 1); tick;

      // 5: misaligned PC becomes an AdEL bubble held until redirect
      drv(0, 32'hBFC00002, 32'h1FC00002, 0, 1, 1, 0, 32'h0);
      lit("t5 misaligned", 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0); tick;
      lit("t5 adel", 0, 0, 32'h0, 1, 32'h0, 32'hBFC00002, 5'd4, 1); tick;
      drv(0, 32'hBFC00002, 32'h1FC00002, 1, 1, 1, 0, 32'h0);
      lit("t5 flush", 0, 0, 32'h0, 1, 32'h0, 32'hBFC00002, 5'd4, 1); tick;
      drv(0, 32'hBFC00300, 32'h1FC00300, 0, 1, 1, 0, 32'h0);
      lit("t5 resume", 1, 1, 32'h1FC00300, 0, 32'h0, 32'h0, 5'd0, 0); tick;

      // 6: reset while waiting with a stale response pending
      drv(0, 32'hBFC00304, 32'h1FC00304, 1, 1, 0, 0, 32'h0);
      lit("t6 flush", 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0); tick;
      drv(1, 32'hBFC00400, 32'h1FC00400, 0, 1, 0, 0, 32'h0);
      lit("t6 reset in wait", 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0); tick;
      drv(0, 32'hBFC00400, 32'h1FC00400, 0, 1, 1, 0, 32'h0);
      lit("t6 after reset", 1, 1, 32'h1FC00400, 0, 32'h0, 32'h0, 5'd0, 1); tick;
      drv(0, 32'hBFC00404, 32'h1FC00404, 0, 1, 0, 1, 32'h33333333);
      lit("t6 wait", 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0); tick;
      drv(0, 32'hBFC00404, 32'h1FC00404, 0, 1, 0, 0, 32'h0);
      lit("t6 deliver", 0, 0, 32'h0, 1, 32'h33333333, 32'hBFC00400, 5'd0, 1); tick;
      lit("idle req", 1, 0, 32'h1FC00404, 0, 32'h0, 32'h0, 5'd0, 0); tick;
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
